// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register (main + skid) with valid/ready handshakes, stage enable and flush.
// Optional stall/bubble statistics counters are compiled in with `define PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
  parameter int unsigned WIDTH      = 272,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_stall,
  output logic [CNT_W-1:0] stat_bubble
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_stage_reg: WIDTH and CNT_W must be >= 1");
  end

  // State encoding is {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               main_v, skid_v;
  logic               acc, pop;

  assign main_v    = state_q[0];
  assign skid_v    = state_q[1];
  assign in_ready  = Rst_n && En && !skid_v;
  assign out_valid = main_v && En;
  assign out_data  = main_q;
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      // Flush wins over En and drops any same-cycle accept or pop.
      state_d = EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (En) begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  // Saturating counters; Flush intentionally leaves them alone.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    if (En && !main_v && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  assign stat_stall  = stall_q;
  assign stat_bubble = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, skid fill/drain, flush, enable freeze, async reset
// and (with PIPE_STAGE_STATS_EN) saturating statistics counters.
module tb_pipe_stage_reg;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  logic          Clk;
  logic          Rst_n;
  logic          En;
  logic          Flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
`ifdef PIPE_STAGE_STATS_EN
  logic [CW-1:0] stat_stall;
  logic [CW-1:0] stat_bubble;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.WIDTH(W), .CLEAR_DATA(1'b1), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .En         (En),
    .Flush      (Flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stat_stall (stat_stall),
    .stat_bubble(stat_bubble)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b1; Flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    #9 Rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: streaming 1,2,3 at full rate
    in_valid = 1'b1; in_data = 16'd1;
    tick();
    chk("s1_v1", 32'(out_valid), 32'd1);
    chk("s1_d1", 32'(out_data),  32'd1);
    in_data = 16'd2;
    tick();
    chk("s1_v2", 32'(out_valid), 32'd1);
    chk("s1_d2", 32'(out_data),  32'd2);
    in_data = 16'd3;
    tick();
    chk("s1_v3", 32'(out_valid), 32'd1);
    chk("s1_d3", 32'(out_data),  32'd3);
    chk("s1_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("s1_drain", 32'(out_valid), 32'd0);

    // 2: fill skid with A,B under back-pressure, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA0A0;
    tick();
    chk("s2_one_v", 32'(out_valid), 32'd1);
    chk("s2_one_rdy", 32'(in_ready), 32'd1);
    in_data = 16'hB0B0;
    tick();
    chk("s2_full_rdy", 32'(in_ready), 32'd0);
    chk("s2_full_d",   32'(out_data), 32'hA0A0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("s2_popA_d",   32'(out_data),  32'hB0B0);
    chk("s2_popA_v",   32'(out_valid), 32'd1);
    chk("s2_popA_rdy", 32'(in_ready),  32'd1);
    tick();
    chk("s2_empty_v", 32'(out_valid), 32'd0);

    // 3: flush while FULL with C offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    chk("s3_full_rdy", 32'(in_ready), 32'd0);
    Flush = 1'b1; in_data = 16'hCCCC; out_ready = 1'b1;
    tick();
    Flush = 1'b0; in_valid = 1'b0;
    chk("s3_flush_v",   32'(out_valid), 32'd0);
    chk("s3_flush_d",   32'(out_data),  32'd0);
    chk("s3_flush_rdy", 32'(in_ready),  32'd1);
    tick();
    chk("s3_no_C", 32'(out_valid), 32'd0);

    // 3b: flush in ONE with a same-cycle accept; the beat is dropped
    in_valid = 1'b1; in_data = 16'h3333; out_ready = 1'b0;
    tick();
    Flush = 1'b1; in_data = 16'h4444;
    tick();
    Flush = 1'b0; in_valid = 1'b0;
    chk("s3b_v", 32'(out_valid), 32'd0);
    chk("s3b_d", 32'(out_data),  32'd0);

    // 4: En=0 freezes a held entry D
    in_valid = 1'b1; in_data = 16'hD00D; out_ready = 1'b0;
    tick();
    En = 1'b0; in_data = 16'hEEEE; out_ready = 1'b1;
    #1;
    chk("s4_frz_v0", 32'(out_valid), 32'd0);
    chk("s4_frz_r0", 32'(in_ready),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_frz_v", 32'(out_valid), 32'd0);
      chk("s4_frz_r", 32'(in_ready),  32'd0);
    end
    En = 1'b1; in_valid = 1'b0;
    #1;
    chk("s4_resume_v", 32'(out_valid), 32'd1);
    chk("s4_resume_d", 32'(out_data),  32'hD00D);
    tick();
    chk("s4_once", 32'(out_valid), 32'd0);

    // 5: asynchronous reset mid-cycle while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h5555;
    tick();
    in_data = 16'h6666;
    tick();
    in_valid = 1'b0;
    chk("s5_full_v", 32'(out_valid), 32'd1);
    #1 Rst_n = 1'b0;
    #1;
    chk("s5_arst_v",   32'(out_valid), 32'd0);
    chk("s5_arst_rdy", 32'(in_ready),  32'd0);
    chk("s5_arst_d",   32'(out_data),  32'd0);
    #1 Rst_n = 1'b1;
    #1;
    chk("s5_rel_v", 32'(out_valid), 32'd0);
    chk("s5_rel_rdy", 32'(in_ready), 32'd1);

`ifdef PIPE_STAGE_STATS_EN
    // 6: counters cleared by reset, stall saturates at 15, bubble counts idle enabled cycles
    chk("s6_stall0",  32'(stat_stall),  32'd0);
    chk("s6_bubble0", 32'(stat_bubble), 32'd0);
    in_valid = 1'b1; in_data = 16'h7777; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("s6_bubble1", 32'(stat_bubble), 32'd1);
    chk("s6_stall_a", 32'(stat_stall),  32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("s6_stall_sat", 32'(stat_stall),  32'd15);
    chk("s6_bubble_hold", 32'(stat_bubble), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("s6_pop_bubble", 32'(stat_bubble), 32'd1);
    tick();
    chk("s6_idle_bubble", 32'(stat_bubble), 32'd2);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("s6_flush_stall",  32'(stat_stall),  32'd15);
    chk("s6_flush_bubble", 32'(stat_bubble), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
